// File: rtl/raster_pkg.sv
// Shared types and geometry for the frame-granular raster scheduler.
package raster_pkg;

  localparam int unsigned WIDTH  = 160;
  localparam int unsigned HEIGHT = 120;
  localparam int unsigned NPIX   = WIDTH * HEIGHT;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Pixel address sweep with incremental column and bottom-up row tracking.
module raster_counter
  import raster_pkg::*;
#(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    col,
  output logic [Y_W-1:0]    row,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    COL_LAST  = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    ROW_TOP   = Y_W'(HEIGHT - 1);

  logic col_wrap;

  always_comb begin
    last     = (addr == ADDR_LAST);
    col_wrap = (col == COL_LAST);
  end

  // Row counts down: address 0 is the top-left pixel, which plots at the highest y.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (start) begin
      addr <= '0;
      col  <= '0;
      row  <= ROW_TOP;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      if (col_wrap) begin
        col <= '0;
        row <= row - Y_W'(1);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/raster_scheduler.sv
// Round-robin per-frame grant of the raster plotter to one of two image sources,
// sweeping every pixel through the granted source's one-cycle-latency bit store.
module raster_scheduler
  import raster_pkg::*;
#(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [1:0]        req,
  input  colour_t           fg0,
  input  colour_t           bg0,
  input  colour_t           fg1,
  input  colour_t           bg1,
  input  logic              pix_bit0,
  input  logic              pix_bit1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output colour_t           color,
  output logic              plot
);

  state_t         state, state_nxt;
  logic           drain_cnt;
  logic           last_src;
  logic           src_q;
  logic           win_src;
  logic           grant_now;
  logic           start;
  logic           step;
  logic           cnt_last;
  logic [X_W-1:0] col_c;
  logic [Y_W-1:0] row_c;
  colour_t        fg_q, bg_q;
  logic           sel_bit;
  logic           s1_valid;
  logic [X_W-1:0] s1_x;
  logic [Y_W-1:0] s1_y;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_counter (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .step   (step),
    .addr   (pix_addr),
    .col    (col_c),
    .row    (row_c),
    .last   (cnt_last)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    grant_now = 1'b0;
    // With both requesting, the source not served last wins; a lone requester always wins.
    win_src   = (req == 2'b11) ? ~last_src : req[1];
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = SWEEP;
          start     = 1'b1;
          grant_now = 1'b1;
        end
      end
      SWEEP: begin
        if (cnt_last) state_nxt = DRAIN;
        else          step      = 1'b1;
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    done    = (state == DONE) ? gnt : 2'b00;
    sel_bit = src_q ? pix_bit1 : pix_bit0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gnt      <= '0;
      src_q    <= 1'b0;
      last_src <= 1'b1;
      fg_q     <= '0;
      bg_q     <= '0;
    end else if (grant_now) begin
      gnt   <= win_src ? 2'b10 : 2'b01;
      src_q <= win_src;
      fg_q  <= win_src ? fg1 : fg0;
      bg_q  <= win_src ? bg1 : bg0;
    end else if (state == DONE) begin
      gnt      <= '0;
      last_src <= src_q;
    end
  end

  // Stage 1 aligns coordinates with the bit returned a cycle after its address.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      plot     <= 1'b0;
      x        <= '0;
      y        <= '0;
      color    <= '0;
    end else begin
      s1_valid <= (state == SWEEP);
      s1_x     <= col_c;
      s1_y     <= row_c;
      plot     <= s1_valid;
      if (s1_valid) begin
        x     <= s1_x;
        y     <= s1_y;
        color <= sel_bit ? fg_q : bg_q;
      end
    end
  end

endmodule

// File: tb/tb_raster_scheduler.sv
// Bench for raster_scheduler: randomized bit stores and colours checked against a
// frame-timeline reference model plus spot checks at the frame landmarks.
module tb_raster_scheduler;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;
  localparam int F    = NPIX + 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [2:0]  fg0 = '0, bg0 = '0, fg1 = '0, bg1 = '0;
  logic        pix_bit0 = 1'b0, pix_bit1 = 1'b0;
  logic [1:0]  gnt, done;
  logic [14:0] pix_addr;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        plot;

  raster_scheduler #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .req      (req),
    .fg0      (fg0),
    .bg0      (bg0),
    .fg1      (fg1),
    .bg1      (bg1),
    .pix_bit0 (pix_bit0),
    .pix_bit1 (pix_bit1),
    .gnt      (gnt),
    .done     (done),
    .pix_addr (pix_addr),
    .x        (x),
    .y        (y),
    .color    (color),
    .plot     (plot)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Source bit stores
  logic mem0 [NPIX];
  logic mem1 [NPIX];
  logic ones0 = 1'b1;

  function automatic logic bit_of(input logic s, input int a);
    if (s) return mem1[a];
    return ones0 ? 1'b1 : mem0[a];
  endfunction

  // One-cycle-latency store read: bit for the address seen last cycle.
  initial begin
    int prev_addr;
    prev_addr = 0;
    forever begin
      @(posedge clock);
      #1;
      pix_bit0  = ones0 ? 1'b1 : mem0[prev_addr];
      pix_bit1  = mem1[prev_addr];
      prev_addr = int'(pix_addr);
    end
  end

  // Reference model: frame timeline t counted from the first sweep cycle.
  logic       m_busy = 1'b0, m_src = 1'b0, m_ptr = 1'b1, m_fresh = 1'b1;
  int         m_t = 0;
  logic [2:0] l_fg = '0, l_bg = '0;
  logic [1:0] e_gnt = '0, e_done = '0;
  logic       e_plot = 1'b0;
  logic [7:0] e_x = '0;
  logic [6:0] e_y = '0;
  logic [2:0] e_col = '0;

  always @(posedge clock or negedge resetn) begin
    int a;
    if (!resetn) begin
      m_busy = 1'b0; m_ptr = 1'b1; m_t = 0; m_src = 1'b0; m_fresh = 1'b1;
      e_gnt = '0; e_done = '0; e_plot = 1'b0; e_x = '0; e_y = '0; e_col = '0;
    end else begin
      if (m_busy) begin
        m_t++;
        if (m_t == NPIX + 3) begin
          m_busy = 1'b0;
          m_ptr  = m_src;
        end
      end else if (req != 2'b00) begin
        if (req == 2'b11)      m_src = (m_ptr == 1'b1) ? 1'b0 : 1'b1;
        else if (req == 2'b01) m_src = 1'b0;
        else                   m_src = 1'b1;
        m_busy = 1'b1; m_t = 0; m_fresh = 1'b0;
        l_fg = m_src ? fg1 : fg0;
        l_bg = m_src ? bg1 : bg0;
      end
      e_gnt  = m_busy ? (m_src ? 2'b10 : 2'b01) : 2'b00;
      e_done = (m_busy && m_t == NPIX + 2) ? e_gnt : 2'b00;
      e_plot = m_busy && m_t >= 2 && m_t <= NPIX + 1;
      if (e_plot) begin
        a     = m_t - 2;
        e_x   = 8'(a % W);
        e_y   = 7'(H - 1 - a / W);
        e_col = bit_of(m_src, a) ? l_fg : l_bg;
      end
    end
  end

  // Monitor, sampled on the falling edge
  int         cyc = 0;
  int         cyc_err = 0;
  int         plot_cnt = 0;
  logic [1:0] prev_gnt = '0;
  int         rise_cyc[$];
  logic [1:0] rise_gnt[$];

  always @(negedge clock) begin
    logic [22:0] obs, exp;
    cyc++;
    obs = {gnt, done, plot, x, y, color};
    exp = {e_gnt, e_done, e_plot, e_x, e_y, e_col};
    if (obs !== exp) cyc_err++;
    if (m_busy && m_t <= NPIX - 1) begin
      if (pix_addr !== 15'(m_t)) cyc_err++;
    end else if (!m_busy && m_fresh) begin
      if (pix_addr !== 15'd0) cyc_err++;
    end
    if (m_busy && m_t == 0) plot_cnt = 0;
    if (plot === 1'b1) plot_cnt++;
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      rise_cyc.push_back(cyc);
      rise_gnt.push_back(gnt);
    end
    prev_gnt = gnt;
    if (resetn && m_busy) begin
      if (m_t == 0)        chk("gnt_cycle0", gnt, e_gnt);
      if (m_t == 2)        chk("first_plot_xy", {plot, x, y}, {1'b1, 8'd0, 7'd119});
      if (m_t == NPIX + 1) chk("last_plot_xy", {plot, x, y}, {1'b1, 8'd159, 7'd0});
      if (m_t == NPIX + 2) begin
        chk("done_pulse", {done, gnt}, {e_gnt, e_gnt});
        chk("plot_count", plot_cnt, NPIX);
      end
    end
  end

  task automatic wait_t(input int tt, input logic s, input int limit, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!(m_busy && m_src == s && m_t == tt) && n < limit);
    if (!(m_busy && m_src == s && m_t == tt)) chk({"timeout_", tag}, 0, 1);
  endtask

  initial begin
    logic [1:0] exp_seq [5];
    exp_seq = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < NPIX; i++) begin
      int xi, yi;
      xi = i % W;
      yi = H - 1 - i / W;
      mem0[i] = 1'($urandom_range(0, 1));
      mem1[i] = 1'((xi + yi) % 2);
    end
    fg0 = 3'b100; bg0 = 3'($urandom); fg1 = 3'b111; bg1 = 3'b000;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {gnt, done, plot, x, y, color, pix_addr}, 38'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    req = 2'b01;

    // Frame aborted by reset at cycle 10000
    wait_t(0, 1'b0, 20, "abort_grant");
    wait_t(10000, 1'b0, 10100, "abort_point");
    resetn = 1'b0;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_plot", plot, 1'b0);
    chk("rst_done", done, 2'b00);
    chk("rst_x", x, 8'd0);
    chk("rst_y", y, 7'd0);
    chk("rst_color", color, 3'd0);
    chk("rst_pix_addr", pix_addr, 15'd0);
    req   = 2'b11;
    ones0 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;

    // Round robin with both requesting; mid-frame colour changes must not leak
    wait_t(0, 1'b0, 20, "f1");
    wait_t(5000, 1'b1, 2 * F, "f2_mid");
    fg1 = 3'b010;
    fg0 = 3'($urandom);
    bg0 = 3'($urandom);
    wait_t(0, 1'b0, F, "f3");
    req = 2'b01;
    wait_t(100, 1'b0, 200, "f3_mid");
    fg0 = 3'($urandom);
    wait_t(NPIX + 2, 1'b0, F, "f3_done");

    // Back-to-back frame from source 0, request dropped mid-frame
    wait_t(500, 1'b0, F, "f4_mid");
    req = 2'b00;
    wait_t(NPIX + 2, 1'b0, F, "f4_done");
    repeat (40) @(posedge clock);
    #1;
    chk("idle_after_drop", {gnt, plot}, 3'd0);

    chk("grant_count", rise_gnt.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rise_gnt.size()) chk($sformatf("grant_seq_%0d", i), rise_gnt[i], exp_seq[i]);
    if (rise_cyc.size() >= 5) begin
      chk("period_rr", rise_cyc[2] - rise_cyc[1], F);
      chk("period_b2b", rise_cyc[4] - rise_cyc[3], F);
    end
    chk("cycle_mismatches", cyc_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
